// File: rtl/seq_divider_32_bit.sv
// Sequential restoring divider, 32-bit signed/unsigned.
// Fixed 33-edge latency from accepted start to done.
module seq_divider_32_bit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  localparam logic [WIDTH-1:0] MIN_NEG =
    {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  state_t           state_nx;
  logic [5:0]       cnt;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] dvd_q;
  logic             neg_q;
  logic             neg_r;
  logic             dz_q;
  logic             ov_q;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]   sh;
  logic [WIDTH+1:0] diff;
  logic             borrow;

  always_comb begin
    dvd_mag = dividend;
    dvs_mag = divisor;
    if (is_signed && dividend[WIDTH-1])
      dvd_mag = -dividend;
    if (is_signed && divisor[WIDTH-1])
      dvs_mag = -divisor;
  end

  // rem < divisor, so a kept difference never reaches bit WIDTH
  always_comb begin
    sh     = {rem_q, quo_q[WIDTH-1]};
    diff   = {1'b0, sh} - {2'b0, dvs_q};
    borrow = diff[WIDTH+1] | diff[WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = CALC;
      CALC: if (cnt == 6'd31) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: state_nx = IDLE;
    endcase
  end

  assign busy = (state == CALC) || (state == FIX);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      dvd_q       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz_q        <= 1'b0;
      ov_q        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            cnt   <= '0;
            rem_q <= '0;
            quo_q <= dvd_mag;
            dvs_q <= dvs_mag;
            dvd_q <= dividend;
            neg_q <= is_signed &
                     (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r <= is_signed & dividend[WIDTH-1];
            dz_q  <= (divisor == '0);
            ov_q  <= is_signed &&
                     (dividend == MIN_NEG) &&
                     (divisor == '1);
          end
        end
        CALC: begin
          cnt <= cnt + 6'd1;
          if (!borrow) begin
            rem_q <= diff[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_q <= sh[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b0};
          end
        end
        FIX: begin
          div_by_zero <= dz_q;
          overflow    <= ov_q;
          if (dz_q) begin
            quotient  <= '1;
            remainder <= dvd_q;
          end else if (ov_q) begin
            quotient  <= MIN_NEG;
            remainder <= '0;
          end else begin
            quotient  <= neg_q ? -quo_q : quo_q;
            remainder <= neg_r ? -rem_q : rem_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
